// File: rtl/mult_scheduler.sv
// mult_scheduler: round-robin front end that shares one sequential multiplier
// between NREQ requesters. A single transaction is in flight at a time:
// grant -> start pulse -> wait for done -> hold response until accepted.
// Optional build macro: MULT_SCHED_TIMEOUT_EN adds a WAIT-state watchdog that
// aborts with rsp_err=1 and a zero product after TIMEOUT cycles.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no transaction; arbiter may grant one requester
// S_ISSUE | one-cycle mult_start pulse with captured operands
// S_WAIT  | waiting for mult_done (or watchdog expiry when enabled)
// S_RESP  | response valid and held stable until rsp_ready

module mult_scheduler #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic                      mult_start,
  output logic [WIDTH-1:0]          mult_a,
  output logic [WIDTH-1:0]          mult_b,
  input  logic                      mult_done,
  input  logic [2*WIDTH-1:0]        mult_product,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [2*WIDTH-1:0]        rsp_product,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int IDW = $clog2(NREQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  if (NREQ < 2 || NREQ > 8) begin : g_nreq_chk
    $error("mult_scheduler: NREQ must be in 2..8");
  end
  if (TIMEOUT < 1) begin : g_tmo_chk
    $error("mult_scheduler: TIMEOUT must be at least 1");
  end

  logic [1:0]       state;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand;
  logic             grant_found;
  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
  end

  // Round-robin search starting just after the last accepted requester.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // One-hot accept, only while idle; nothing is queued for a later cycle.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign mult_start = (state == S_ISSUE);
  assign rsp_valid  = (state == S_RESP);
  assign busy       = (state != S_IDLE);

`ifdef MULT_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  // Sequencer: capture on accept, pulse, wait for the multiplier, hold response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      last_grant  <= IDW'(NREQ - 1);
      rsp_id      <= '0;
      mult_a      <= '0;
      mult_b      <= '0;
      rsp_product <= '0;
`ifdef MULT_SCHED_TIMEOUT_EN
      rsp_err     <= 1'b0;
      tmo_cnt     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            state      <= S_ISSUE;
            last_grant <= grant_idx;
            rsp_id     <= grant_idx;
            mult_a     <= a_arr[grant_idx];
            mult_b     <= b_arr[grant_idx];
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
`ifdef MULT_SCHED_TIMEOUT_EN
          // Down-counter reaches zero on the last allowed WAIT cycle.
          tmo_cnt <= CW'(TIMEOUT - 1);
`endif
        end
        S_WAIT: begin
          if (mult_done) begin
            rsp_product <= mult_product;
`ifdef MULT_SCHED_TIMEOUT_EN
            rsp_err     <= 1'b0;
`endif
            state       <= S_RESP;
          end
`ifdef MULT_SCHED_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            rsp_product <= '0;
            rsp_err     <= 1'b1;
            state       <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt - CW'(1);
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed bench for mult_scheduler with a behavioural fixed-latency multiplier.
module tb_mult_scheduler;

  localparam int WIDTH   = 8;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        mult_start;
  logic [7:0]  mult_a, mult_b;
  logic        mult_done;
  logic [15:0] mult_product;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_product;
  logic        rsp_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  mult_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_done(mult_done), .mult_product(mult_product),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier model: done pulses for one cycle, lat cycles after mult_start.
  int         model_lat = 8;
  logic       model_en = 1'b1;
  int         model_cnt = 0;
  logic       model_done = 1'b0;
  logic       stray_done = 1'b0;
  logic [7:0] pa = '0, pb = '0;

  assign mult_done    = model_done | stray_done;
  assign mult_product = {8'h00, pa} * {8'h00, pb};

  always @(negedge clk) begin
    model_done = 1'b0;
    if (model_cnt > 0) begin
      model_cnt = model_cnt - 1;
      if (model_cnt == 0) model_done = 1'b1;
    end
    if (mult_start && model_en) begin
      model_cnt = model_lat;
      pa = mult_a;
      pb = mult_b;
    end
  end

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] a_bus;
    logic [31:0] b_bus;
    int          lat;
    int          rdy_delay;
    logic        stray;
    logic [1:0]  exp_id;
    logic [15:0] exp_prod;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns one cycle after the handshake.
  task automatic run_vec(input vec_t v);
    int   n;
    logic ready_bad;
    logic bp_bad;
    req_valid = v.valid;
    req_a     = v.a_bus;
    req_b     = v.b_bus;
    model_lat = v.lat;
    #1;
    chk("accept_grant", 32'(req_ready), 32'(1) << v.exp_id);
    @(negedge clk);
    if (v.stray) stray_done = 1'b1;
    #1;
    chk("issue_start", 32'(mult_start), 32'd1);
    chk("issue_a", 32'(mult_a), 32'(v.a_bus[v.exp_id*8 +: 8]));
    chk("issue_b", 32'(mult_b), 32'(v.b_bus[v.exp_id*8 +: 8]));
    ready_bad = (req_ready !== 4'b0000);
    @(negedge clk);
    stray_done = 1'b0;
    n = 2;
    #1;
    while (!rsp_valid && n < 300) begin
      if (req_ready !== 4'b0000) ready_bad = 1'b1;
      if (mult_start !== 1'b0) ready_bad = 1'b1;
      @(negedge clk);
      n++;
      #1;
    end
    chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    if (rsp_valid !== 1'b1) return;
    chk("latency", n, v.lat + 2);
    chk("rsp_id", 32'(rsp_id), 32'(v.exp_id));
    chk("rsp_product", 32'(rsp_product), 32'(v.exp_prod));
    chk("rsp_err", 32'(rsp_err), 32'd0);
    bp_bad = 1'b0;
    for (int k = 0; k < v.rdy_delay; k++) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== 1'b1 || rsp_id !== v.exp_id || rsp_product !== v.exp_prod)
        bp_bad = 1'b1;
      if (req_ready !== 4'b0000) ready_bad = 1'b1;
    end
    if (v.rdy_delay > 0) chk("backpressure_hold", 32'(bp_bad), 32'd0);
    chk("no_ready_while_busy", 32'(ready_bad), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("post_hs_busy", 32'(busy), 32'd0);
    chk("post_hs_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int   n;
    logic late_bad;
    vec_t hv;

    vecs[0] = '{4'b0001, 32'h0000_0007, 32'h0000_0003, 8, 0, 1'b0, 2'd0, 16'h0015};
    vecs[1] = '{4'b1111, 32'hFF0C_0502, 32'hFF0B_0981, 1, 0, 1'b0, 2'd1, 16'h002D};
    vecs[2] = '{4'b1111, 32'hFF0C_0502, 32'hFF0B_0981, 3, 5, 1'b0, 2'd2, 16'h0084};
    vecs[3] = '{4'b1111, 32'hFF0C_0502, 32'hFF0B_0981, 5, 1, 1'b0, 2'd3, 16'hFE01};
    vecs[4] = '{4'b1111, 32'hFF0C_0502, 32'hFF0B_0981, 2, 0, 1'b1, 2'd0, 16'h0102};
    vecs[5] = '{4'b1111, 32'hFF0C_0502, 32'hFF0B_0981, 4, 0, 1'b0, 2'd1, 16'h002D};
    vecs[6] = '{4'b1010, 32'h8000_1100, 32'h0200_0300, 3, 0, 1'b0, 2'd3, 16'h0100};
    vecs[7] = '{4'b1010, 32'h8000_1100, 32'h0200_0300, 2, 0, 1'b0, 2'd1, 16'h0033};
    vecs[8] = '{4'b0100, 32'h00E0_0000, 32'h0010_0000, 6, 0, 1'b0, 2'd2, 16'h0E00};
    vecs[9] = '{4'b0001, 32'h0000_0000, 32'h0000_0055, 1, 2, 1'b0, 2'd0, 16'h0000};

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mult_start", 32'(mult_start), 32'd0);
    chk("rst_rsp_product", 32'(rsp_product), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_mult_a", 32'(mult_a), 32'd0);
    chk("rst_mult_b", 32'(mult_b), 32'd0);
    rst_n = 1'b1;

    // Stray done while idle
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    #1;
    chk("idle_stray_busy", 32'(busy), 32'd0);
    chk("idle_stray_valid", 32'(rsp_valid), 32'd0);
    chk("idle_ready_zero", 32'(req_ready), 32'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);
    req_valid = 4'b0000;

`ifndef MULT_SCHED_TIMEOUT_EN
    // Without the watchdog a long multiply just keeps WAIT busy.
    hv = '{4'b0100, 32'h0009_0000, 32'h0009_0000, 90, 0, 1'b0, 2'd2, 16'h0051};
    run_vec(hv);
    req_valid = 4'b0000;
`endif

    // Reset in the middle of WAIT, then a late done from the multiplier.
    req_valid = 4'b0001;
    req_a     = 32'h0000_0007;
    req_b     = 32'h0000_0003;
    model_lat = 8;
    #1;
    chk("rstw_grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_valid", 32'(rsp_valid), 32'd0);
    chk("rstw_mult_a", 32'(mult_a), 32'd0);
    late_bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      #1;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) late_bad = 1'b1;
    end
    chk("rstw_late_done_ignored", 32'(late_bad), 32'd0);
    hv = '{4'b1111, 32'hFF0C_0502, 32'hFF0B_0981, 4, 0, 1'b0, 2'd0, 16'h0102};
    run_vec(hv);
    req_valid = 4'b0000;

`ifdef MULT_SCHED_TIMEOUT_EN
    // Watchdog: no done at all, abort TIMEOUT cycles after WAIT entry.
    model_en  = 1'b0;
    req_valid = 4'b0010;
    req_a     = 32'h0000_0500;
    req_b     = 32'h0000_0900;
    #1;
    chk("tmo_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 4'b0000;
    n = 1;
    #1;
    while (!rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
      #1;
    end
    chk("tmo_latency", n, TIMEOUT + 2);
    chk("tmo_err", 32'(rsp_err), 32'd1);
    chk("tmo_product", 32'(rsp_product), 32'd0);
    chk("tmo_id", 32'(rsp_id), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("tmo_post_busy", 32'(busy), 32'd0);
    model_en = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
